axis_burst_writer: RTL and testbench
====================================

AXIS_BURST_WRITER -- requirements
Module: axis_burst_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, stream/AXI data width in bits (multiple of 8, at least 64).
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, byte-lane count.
REQ-003 SHALL have parameter ADDR_WIDTH, default 34, AXI address width.
REQ-004 SHALL have parameter MAX_BURST_LEN, default 16, maximum beats per burst (power of two, 2..256).
REQ-005 SHALL have ports clk in 1, sole clock, and rst_n in 1, asynchronous active-low reset; one clock, no other clock domain.
REQ-006 SHALL have ports s_axis_tdata in DATA_WIDTH, s_axis_tkeep in KEEP_WIDTH, s_axis_tlast in 1, s_axis_tvalid in 1, s_axis_tready out 1: the frame stream drained from the capture FIFO.
REQ-007 SHALL have ports axi_base_addr in ADDR_WIDTH and axi_base_addr_valid in 1: the destination address for the next frame.
REQ-008 SHALL have AW-channel ports: m_axi_awid out 6, m_axi_awaddr out ADDR_WIDTH, m_axi_awlen out 8, m_axi_awsize out 3, m_axi_awburst out 2, m_axi_awlock out 1, m_axi_awcache out 4, m_axi_awprot out 3, m_axi_awvalid out 1, m_axi_awready in 1.
REQ-009 SHALL have W/B-channel ports: m_axi_wdata out DATA_WIDTH, m_axi_wstrb out KEEP_WIDTH, m_axi_wlast out 1, m_axi_wvalid out 1, m_axi_wready in 1, m_axi_bid in 6, m_axi_bresp in 2, m_axi_bvalid in 1, m_axi_bready out 1.
REQ-010 SHALL have status ports busy out 1, frame_done out 1 (one-cycle pulse), err_bresp out 1 (sticky), beat_count out 32.

Function
REQ-011 SHALL drive constants: awid 0, awsize log2(KEEP_WIDTH), awburst 2'b01 INCR, awlock 0, awcache 4'b0011, awprot 0.
REQ-012 SHALL implement states IDLE, FILL, ADDR, DATA, RESP.
REQ-013 IDLE: on axi_base_addr_valid, SHALL latch axi_base_addr with its low log2(KEEP_WIDTH) bits forced to zero into cur_addr and go to FILL next cycle; busy is 0 only in IDLE.
REQ-014 SHALL hold s_axis_tready 0 in every state except FILL; beats are never accepted without a latched address.
REQ-015 FILL: SHALL store each accepted beat (tdata, tkeep) into an internal MAX_BURST_LEN-entry buffer and increment fill_cnt.
REQ-016 burst_limit SHALL equal min(MAX_BURST_LEN, (4096 - cur_addr[11:0]) / KEEP_WIDTH); no burst crosses a 4 KB boundary.
REQ-017 FILL SHALL exit to ADDR on the cycle after the beat that makes fill_cnt equal burst_limit or that carries tlast; last_seg is set when that beat had tlast.
REQ-018 ADDR: SHALL assert awvalid with awaddr=cur_addr and awlen=fill_cnt-1, holding both stable until awready; on handshake, go to DATA.
REQ-019 DATA: SHALL present buffer entries in order on wdata/wstrb (wstrb = stored tkeep) with wvalid=1, advance on wready, and assert wlast on entry fill_cnt-1; after the wlast handshake, go to RESP.
REQ-020 RESP: SHALL assert bready=1; on bvalid, set err_bresp if bresp != 2'b00, then add fill_cnt*KEEP_WIDTH to cur_addr and clear fill_cnt.
REQ-021 After RESP: if last_seg, SHALL pulse frame_done for one cycle and go to IDLE; otherwise go to FILL with no idle cycle.
REQ-022 beat_count SHALL increment by 1 per W handshake and wrap modulo 2^32.
REQ-023 SHALL ignore axi_base_addr_valid outside IDLE.
REQ-024 SHALL not issue a second AW before the prior B response (one outstanding burst).
REQ-025 Single-beat frame (tvalid and tlast on the first beat) SHALL produce awlen=0 and wlast on the sole beat.
REQ-026 cur_addr SHALL wrap modulo 2^ADDR_WIDTH.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, clear fill_cnt, last_seg, err_bresp and beat_count, and drive awvalid, wvalid, wlast, bready, s_axis_tready, busy and frame_done to 0.
REQ-028 Reset mid-burst SHALL abandon the burst with no further AW/W activity; buffered beats are discarded.

Verification
REQ-029 Base 0x0, 3-beat frame with full tkeep -> one AW (awaddr 0x0, awlen 2), 3 W beats with wlast on the third, frame_done pulse, beat_count=3.
REQ-030 Base 0x0, 40-beat frame with MAX_BURST_LEN=16 -> AW at 0x0/0x400/0x800 with awlen 15/15/7.
REQ-031 Base 0xFC0, KEEP_WIDTH=64, 4-beat frame -> AW 0xFC0 awlen 0, then AW 0x1000 awlen 2.
REQ-032 awready and wready held low for 5 cycles -> awvalid/awaddr/wdata held stable; no beat lost or duplicated.
REQ-033 bresp=2'b10 on the first burst -> err_bresp=1 and stays 1 through subsequent good bursts until reset.
REQ-034 rst_n low during DATA after 2 of 8 beats -> all outputs 0 within the same cycle; a new frame after release starts from IDLE.

Source files
------------

// File: rtl/axis_burst_writer.sv
// Drains frames from a capture-FIFO stream into AXI4 INCR write bursts. Each
// burst is buffered in full before its AW is issued, so AW and W stay simple
// and only one burst is ever outstanding. No burst crosses a 4 KB boundary.
module axis_burst_writer #(
    parameter int DATA_WIDTH    = 512,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH    = 34,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [ADDR_WIDTH-1:0] axi_base_addr,
    input  logic                  axi_base_addr_valid,
    output logic [5:0]            m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [KEEP_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [5:0]            m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err_bresp,
    output logic [31:0]           beat_count
);
    localparam int LOG2K = $clog2(KEEP_WIDTH);
    localparam int PW    = $clog2(MAX_BURST_LEN);
    localparam int CW    = PW + 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(KEEP_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, FILL, ADDR, DATA, RESP} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [CW-1:0]         fill_cnt_q, fill_cnt_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  last_seg_q, last_seg_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;
    logic [31:0]           beat_cnt_q, beat_cnt_d;

    logic [DATA_WIDTH-1:0] data_buf [MAX_BURST_LEN];
    logic [KEEP_WIDTH-1:0] keep_buf [MAX_BURST_LEN];

    logic [12:0]           room_beats;
    logic [CW-1:0]         burst_limit;
    logic                  beat_acc;
    logic                  unused_bid;

    assign unused_bid = ^m_axi_bid;

    // Beats left before the next 4 KB boundary, clipped to the burst maximum
    always_comb begin
        room_beats  = (13'h1000 - {1'b0, cur_addr_q[11:0]}) >> LOG2K;
        burst_limit = (room_beats > 13'(MAX_BURST_LEN)) ? CW'(MAX_BURST_LEN) : CW'(room_beats);
    end

    assign s_axis_tready = (state_q == FILL);
    assign beat_acc      = s_axis_tvalid && s_axis_tready;

    assign m_axi_awid    = 6'd0;
    assign m_axi_awsize  = 3'(LOG2K);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'd0;
    assign m_axi_awvalid = (state_q == ADDR);
    assign m_axi_awaddr  = cur_addr_q;
    assign m_axi_awlen   = 8'(fill_cnt_q - CW'(1));

    assign m_axi_wvalid  = (state_q == DATA);
    assign m_axi_wdata   = data_buf[rd_ptr_q];
    assign m_axi_wstrb   = keep_buf[rd_ptr_q];
    assign m_axi_wlast   = (state_q == DATA) && ({1'b0, rd_ptr_q} == fill_cnt_q - CW'(1));
    assign m_axi_bready  = (state_q == RESP);

    assign busy          = (state_q != IDLE);
    assign frame_done    = done_q;
    assign err_bresp     = err_q;
    assign beat_count    = beat_cnt_q;

    // Burst buffer: payload only, never needs reset (stale entries are never read)
    always_ff @(posedge clk) begin
        if (beat_acc) begin
            data_buf[fill_cnt_q[PW-1:0]] <= s_axis_tdata;
            keep_buf[fill_cnt_q[PW-1:0]] <= s_axis_tkeep;
        end
    end

    // Next-state and bookkeeping for the fill / address / data / response cycle
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        fill_cnt_d = fill_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        last_seg_d = last_seg_q;
        err_d      = err_q;
        done_d     = 1'b0;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (axi_base_addr_valid) begin
                    cur_addr_d = axi_base_addr & ALIGN_MASK;
                    state_d    = FILL;
                end
            end
            FILL: begin
                if (beat_acc) begin
                    fill_cnt_d = fill_cnt_q + CW'(1);
                    if (fill_cnt_d == burst_limit || s_axis_tlast) begin
                        last_seg_d = s_axis_tlast;
                        state_d    = ADDR;
                    end
                end
            end
            ADDR: begin
                if (m_axi_awready) begin
                    rd_ptr_d = '0;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (m_axi_wready) begin
                    rd_ptr_d   = rd_ptr_q + PW'(1);
                    beat_cnt_d = beat_cnt_q + 32'd1;
                    if (m_axi_wlast) state_d = RESP;
                end
            end
            RESP: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00) err_d = 1'b1;
                    cur_addr_d = cur_addr_q + (ADDR_WIDTH'(fill_cnt_q) << LOG2K);
                    fill_cnt_d = '0;
                    if (last_seg_q) begin
                        done_d     = 1'b1;
                        last_seg_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        state_d    = FILL;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and control registers; reset abandons any burst in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            fill_cnt_q <= '0;
            rd_ptr_q   <= '0;
            last_seg_q <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            fill_cnt_q <= fill_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            last_seg_q <= last_seg_d;
            err_q      <= err_d;
            done_q     <= done_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end
endmodule

// File: tb/tb_axis_burst_writer.sv
// Bench for axis_burst_writer: a table of frames, each expanded by a small
// model into expected AW/W/B traffic, checked by an AXI slave responder.
`timescale 1ns/1ps
module tb_axis_burst_writer;
    localparam int DW = 512, KW = 64, AW = 34, MBL = 16;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          s_axis_tlast, s_axis_tvalid, s_axis_tready;
    logic [AW-1:0] axi_base_addr;
    logic          axi_base_addr_valid;
    logic [5:0]    m_axi_awid;
    logic [AW-1:0] m_axi_awaddr;
    logic [7:0]    m_axi_awlen;
    logic [2:0]    m_axi_awsize;
    logic [1:0]    m_axi_awburst;
    logic          m_axi_awlock;
    logic [3:0]    m_axi_awcache;
    logic [2:0]    m_axi_awprot;
    logic          m_axi_awvalid, m_axi_awready;
    logic [DW-1:0] m_axi_wdata;
    logic [KW-1:0] m_axi_wstrb;
    logic          m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [5:0]    m_axi_bid;
    logic [1:0]    m_axi_bresp;
    logic          m_axi_bvalid, m_axi_bready;
    logic          busy, frame_done, err_bresp;
    logic [31:0]   beat_count;

    axis_burst_writer #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ADDR_WIDTH(AW), .MAX_BURST_LEN(MBL)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .axi_base_addr(axi_base_addr), .axi_base_addr_valid(axi_base_addr_valid),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .busy(busy), .frame_done(frame_done), .err_bresp(err_bresp), .beat_count(beat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } aw_exp_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] strb;
        logic          last;
    } w_exp_t;

    typedef struct {
        logic [AW-1:0] base;
        int            nbeats;
        int            aw_stall;
        int            w_stall;
        int            err_burst;
        logic          exp_err;
        logic [31:0]   exp_bc;
    } vec_t;

    aw_exp_t    aw_q[$];
    w_exp_t     w_q[$];
    logic [1:0] bresp_q[$];
    vec_t       tbl[8];

    int n_chk = 0, n_err = 0;
    int aw_stall = 0, w_stall = 0, w_hs_cnt = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input int fid, input int b);
        return {16{16'(fid), 16'(b)}};
    endfunction

    task automatic chk_quiet(input string tag);
        chk($sformatf("%s awvalid", tag), m_axi_awvalid, 0);
        chk($sformatf("%s wvalid", tag), m_axi_wvalid, 0);
        chk($sformatf("%s wlast", tag), m_axi_wlast, 0);
        chk($sformatf("%s bready", tag), m_axi_bready, 0);
        chk($sformatf("%s tready", tag), s_axis_tready, 0);
        chk($sformatf("%s busy", tag), busy, 0);
        chk($sformatf("%s frame_done", tag), frame_done, 0);
        chk($sformatf("%s err_bresp", tag), err_bresp, 0);
        chk($sformatf("%s beat_count", tag), beat_count, 0);
    endtask

    // Push the expected AXI traffic for a frame, then stream its beats in
    task automatic drive_frame(input logic [AW-1:0] base, input int n, input int err_burst, input int fid);
        logic [KW-1:0] kp[];
        logic [AW-1:0] addr;
        aw_exp_t       ae;
        w_exp_t        we;
        int            b, seg, lim, len, cyc;
        bit            taken;
        kp = new[n];
        for (int i = 0; i < n; i++) kp[i] = (i == n - 1) ? ({$urandom, $urandom} | 64'h1) : '1;
        addr = base & ~AW'(KW - 1);
        b = 0;
        seg = 0;
        while (b < n) begin
            lim = (4096 - int'(addr[11:0])) / KW;
            if (lim > MBL) lim = MBL;
            len = (n - b < lim) ? n - b : lim;
            ae.addr = addr;
            ae.len  = 8'(len - 1);
            aw_q.push_back(ae);
            bresp_q.push_back((seg == err_burst) ? 2'b10 : 2'b00);
            for (int k = 0; k < len; k++) begin
                we.data = beat_data(fid, b + k);
                we.strb = kp[b + k];
                we.last = (k == len - 1);
                w_q.push_back(we);
            end
            b    += len;
            addr += AW'(len * KW);
            seg++;
        end
        @(posedge clk); #1;
        axi_base_addr       = base;
        axi_base_addr_valid = 1'b1;
        @(posedge clk); #1;
        // Leave valid high with a bogus address: only the IDLE sample may count
        axi_base_addr = 34'h2_AAAA_0000;
        for (int i = 0; i < n; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = beat_data(fid, i);
            s_axis_tkeep  = kp[i];
            s_axis_tlast  = (i == n - 1);
            taken = 1'b0;
            cyc   = 0;
            while (!taken && cyc < 500) begin
                #3;
                taken = s_axis_tready;
                @(posedge clk); #1;
                cyc++;
            end
            if (!taken) chk("tready_timeout", 0, 1);
        end
        s_axis_tvalid       = 1'b0;
        s_axis_tlast        = 1'b0;
        s_axis_tkeep        = '0;
        axi_base_addr_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int cyc;
        cyc = 0;
        chk($sformatf("%s busy", tag), busy, 1);
        while (frame_done !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("%s frame_done", tag), frame_done, 1);
        @(negedge clk);
        chk($sformatf("%s done_pulse", tag), frame_done, 0);
        chk($sformatf("%s busy_idle", tag), busy, 0);
    endtask

    // AXI slave responder and checker; decides readies at the falling edge so
    // handshakes complete at the following rising edge
    initial begin
        int            aw_wait, w_wait;
        bit            b_hs, b_pend, outst, aw_held, w_held;
        logic [AW-1:0] prev_awaddr;
        logic [7:0]    prev_awlen;
        logic [DW-1:0] prev_wdata;
        aw_exp_t       ae;
        w_exp_t        we;
        aw_wait = 0; w_wait = 0; b_hs = 0; b_pend = 0; outst = 0; aw_held = 0; w_held = 0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
        m_axi_bresp = 2'b00; m_axi_bid = 6'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
                aw_wait = 0; w_wait = 0; b_hs = 0; b_pend = 0; outst = 0; aw_held = 0; w_held = 0;
                continue;
            end
            if (m_axi_awvalid || m_axi_wvalid || m_axi_bready || !busy)
                chk("tready_low", s_axis_tready, 0);
            // B channel
            if (b_hs) begin
                m_axi_bvalid = 1'b0;
                b_hs  = 0;
                outst = 0;
            end
            if (b_pend && !m_axi_bvalid) begin
                m_axi_bvalid = 1'b1;
                m_axi_bresp  = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
                b_pend = 0;
            end
            if (m_axi_bvalid && m_axi_bready) b_hs = 1;
            // AW channel
            if (m_axi_awvalid) begin
                if (aw_held) begin
                    chk("awaddr_stable", m_axi_awaddr, prev_awaddr);
                    chk("awlen_stable", m_axi_awlen, prev_awlen);
                end
                if (aw_wait >= aw_stall) begin
                    m_axi_awready = 1'b1;
                    aw_wait = 0;
                    aw_held = 0;
                    chk("aw_outstanding", outst, 0);
                    outst = 1;
                    chk("aw_const", {m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot},
                        {6'd0, 3'd6, 2'b01, 1'b0, 4'b0011, 3'd0});
                    if (aw_q.size() == 0) chk("aw_unexpected", m_axi_awaddr, 'x);
                    else begin
                        ae = aw_q.pop_front();
                        chk("awaddr", m_axi_awaddr, ae.addr);
                        chk("awlen", m_axi_awlen, ae.len);
                    end
                end else begin
                    m_axi_awready = 1'b0;
                    aw_wait++;
                    aw_held = 1;
                    prev_awaddr = m_axi_awaddr;
                    prev_awlen  = m_axi_awlen;
                end
            end else m_axi_awready = 1'b0;
            // W channel
            if (m_axi_wvalid) begin
                if (w_held) chk("wdata_stable", m_axi_wdata, prev_wdata);
                if (w_wait >= w_stall) begin
                    m_axi_wready = 1'b1;
                    w_wait = 0;
                    w_held = 0;
                    w_hs_cnt++;
                    if (w_q.size() == 0) chk("w_unexpected", m_axi_wdata, 'x);
                    else begin
                        we = w_q.pop_front();
                        chk("wdata", m_axi_wdata, we.data);
                        chk("wstrb", m_axi_wstrb, we.strb);
                        chk("wlast", m_axi_wlast, we.last);
                    end
                    if (m_axi_wlast) b_pend = 1;
                end else begin
                    m_axi_wready = 1'b0;
                    w_wait++;
                    w_held = 1;
                    prev_wdata = m_axi_wdata;
                end
            end else m_axi_wready = 1'b0;
        end
    end

    initial begin
        int cyc;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0;
        axi_base_addr = '0; axi_base_addr_valid = 1'b0;
        //          base            beats awst wst errb err  beat_count
        tbl[0] = '{34'h0,           3,    0,   0,  -1,  1'b0, 32'd3};
        tbl[1] = '{34'h0,           40,   0,   0,  -1,  1'b0, 32'd43};
        tbl[2] = '{34'hFC0,         4,    0,   0,  -1,  1'b0, 32'd47};
        tbl[3] = '{34'h1234,        1,    0,   0,  -1,  1'b0, 32'd48};
        tbl[4] = '{34'h2000,        6,    5,   5,  -1,  1'b0, 32'd54};
        tbl[5] = '{34'h3F00,        10,   0,   1,  0,   1'b1, 32'd64};
        tbl[6] = '{34'h5000,        5,    2,   0,  -1,  1'b1, 32'd69};
        tbl[7] = '{34'h3_FFFF_FFC0, 3,    0,   0,  -1,  1'b1, 32'd72};

        #12;
        chk_quiet("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_quiet("after_reset");

        for (int i = 0; i < 8; i++) begin
            aw_stall = tbl[i].aw_stall;
            w_stall  = tbl[i].w_stall;
            drive_frame(tbl[i].base, tbl[i].nbeats, tbl[i].err_burst, i + 1);
            wait_done($sformatf("v%0d", i));
            chk($sformatf("v%0d err_bresp", i), err_bresp, tbl[i].exp_err);
            chk($sformatf("v%0d beat_count", i), beat_count, tbl[i].exp_bc);
            chk($sformatf("v%0d aw_left", i), aw_q.size(), 0);
            chk($sformatf("v%0d w_left", i), w_q.size(), 0);
        end

        // Reset in the middle of the data phase, after two of eight beats
        aw_stall = 0;
        w_stall  = 0;
        w_hs_cnt = 0;
        drive_frame(34'h8000, 8, -1, 20);
        cyc = 0;
        while (w_hs_cnt < 2 && cyc < 200) begin
            @(posedge clk); #2;
            cyc++;
        end
        chk("mid w_hs_cnt", w_hs_cnt, 2);
        chk("mid beat_count", beat_count, 32'd74);
        chk("mid wvalid", m_axi_wvalid, 1);
        rst_n = 1'b0;
        #1;
        chk_quiet("midreset");
        aw_q.delete();
        w_q.delete();
        bresp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_reset busy", busy, 0);
        chk("post_reset awvalid", m_axi_awvalid, 0);
        chk("post_reset wvalid", m_axi_wvalid, 0);
        chk("post_reset w_hs_cnt", w_hs_cnt, 2);

        drive_frame(34'h100, 3, -1, 21);
        wait_done("restart");
        chk("restart beat_count", beat_count, 32'd3);
        chk("restart err_bresp", err_bresp, 0);
        chk("restart aw_left", aw_q.size(), 0);
        chk("restart w_left", w_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
